// File: rtl/rv32i_operand_fetch.sv
// rv32i_operand_fetch: register-file read sequencer between fetch and execute.
// Define RV32I_OPFETCH_BYPASS_EN to forward writeback data; otherwise a hazard re-reads the BRAM.
module rv32i_operand_fetch #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_BITS = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   input  logic [31:0]         instr_i,
   input  logic [XLEN-1:0]     pc_i,
   output logic [REG_BITS-1:0] rs1_addr_o,
   output logic [REG_BITS-1:0] rs2_addr_o,
   input  logic [XLEN-1:0]     rs1_data_i,
   input  logic [XLEN-1:0]     rs2_data_i,
   input  logic                wb_write_i,
   input  logic [REG_BITS-1:0] wb_rd_addr_i,
   input  logic [XLEN-1:0]     wb_data_i,
   input  logic                flush_i,
   output logic                op_valid_o,
   input  logic                op_ready_i,
   output logic [XLEN-1:0]     op_rs1_o,
   output logic [XLEN-1:0]     op_rs2_o,
   output logic [31:0]         op_instr_o,
   output logic [XLEN-1:0]     op_pc_o
);

   localparam int unsigned HOLD_BITS = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_FETCH = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_instr;
   logic [XLEN-1:0]       r_pc;
   logic [REG_BITS-1:0]   r_rs1_addr;
   logic [REG_BITS-1:0]   r_rs2_addr;
   logic                  r_op_valid;
   logic [XLEN-1:0]       r_op_rs1;
   logic [XLEN-1:0]       r_op_rs2;
   logic [HOLD_BITS-1:0]  r_hold;

   logic                  w_instr_ready;
   logic                  w_accept;
   logic                  w_restart;
   logic                  w_capture;
   logic                  w_hit1;
   logic                  w_hit2;
   logic [XLEN-1:0]       w_rs1_cap;
   logic [XLEN-1:0]       w_rs2_cap;

   // A writeback hits an operand only when it targets that operand's non-zero register.
   assign w_hit1   = wb_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == r_rs1_addr);
   assign w_hit2   = wb_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == r_rs2_addr);
   assign w_accept = instr_valid_i && w_instr_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
         S_SETUP: w_state_nxt = (w_restart || (r_hold != '0)) ? S_SETUP : S_FETCH;
         S_FETCH: w_state_nxt = w_restart ? S_SETUP : S_VALID;
         S_VALID: begin
            if (op_ready_i)     w_state_nxt = w_accept ? S_SETUP : S_IDLE;
            else if (w_restart) w_state_nxt = S_SETUP;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush_i) w_state_nxt = S_IDLE;
   end

   always_comb begin
      w_instr_ready = 1'b0;
      w_restart     = 1'b0;
      case (r_state)
         S_IDLE:  w_instr_ready = 1'b1;
         S_VALID: w_instr_ready = op_ready_i;
         default: w_instr_ready = 1'b0;
      endcase
      if (flush_i) w_instr_ready = 1'b0;
`ifndef RV32I_OPFETCH_BYPASS_EN
      // Without forwarding, a hit on an unconsumed operand forces a fresh read.
      if ((r_state != S_IDLE) && (w_hit1 || w_hit2) && !((r_state == S_VALID) && op_ready_i))
         w_restart = 1'b1;
`endif
      w_capture = (r_state == S_FETCH) && (w_state_nxt == S_VALID);
   end

`ifdef RV32I_OPFETCH_BYPASS_EN
   logic            r_fwd1;
   logic            r_fwd2;
   logic [XLEN-1:0] r_fwd1_data;
   logic [XLEN-1:0] r_fwd2_data;

   // Writes landing while the BRAM samples are invisible to its output; remember them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fwd1      <= 1'b0;
         r_fwd2      <= 1'b0;
         r_fwd1_data <= '0;
         r_fwd2_data <= '0;
      end else if (w_accept || flush_i) begin
         r_fwd1 <= 1'b0;
         r_fwd2 <= 1'b0;
      end else if (r_state == S_SETUP) begin
         if (w_hit1) begin
            r_fwd1      <= 1'b1;
            r_fwd1_data <= wb_data_i;
         end
         if (w_hit2) begin
            r_fwd2      <= 1'b1;
            r_fwd2_data <= wb_data_i;
         end
      end
   end
`else
   logic w_unused_wb_data;
   assign w_unused_wb_data = ^wb_data_i;
`endif

   always_comb begin
      w_rs1_cap = rs1_data_i;
      w_rs2_cap = rs2_data_i;
`ifdef RV32I_OPFETCH_BYPASS_EN
      if (w_hit1)      w_rs1_cap = wb_data_i;
      else if (r_fwd1) w_rs1_cap = r_fwd1_data;
      if (w_hit2)      w_rs2_cap = wb_data_i;
      else if (r_fwd2) w_rs2_cap = r_fwd2_data;
`endif
      if (r_rs1_addr == '0) w_rs1_cap = '0;
      if (r_rs2_addr == '0) w_rs2_cap = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_instr    <= '0;
         r_pc       <= '0;
         r_rs1_addr <= '0;
         r_rs2_addr <= '0;
         r_op_valid <= 1'b0;
         r_op_rs1   <= '0;
         r_op_rs2   <= '0;
         r_hold     <= '0;
      end else begin
         r_op_valid <= (w_state_nxt == S_VALID);
         if (w_accept) begin
            r_instr    <= instr_i;
            r_pc       <= pc_i;
            r_rs1_addr <= REG_BITS'(instr_i[19:15]);
            r_rs2_addr <= REG_BITS'(instr_i[24:20]);
         end
         if (w_capture) begin
            r_op_rs1 <= w_rs1_cap;
            r_op_rs2 <= w_rs2_cap;
         end
`ifdef RV32I_OPFETCH_BYPASS_EN
         else if (r_state == S_VALID) begin
            if (w_hit1) r_op_rs1 <= wb_data_i;
            if (w_hit2) r_op_rs2 <= wb_data_i;
         end
`endif
         // A restart from SETUP costs two extra SETUP cycles, the same as one from FETCH.
         if (flush_i) begin
            r_hold <= '0;
         end else if (r_state == S_SETUP) begin
            if (w_restart) begin
               if (r_hold != '1) r_hold <= r_hold + HOLD_BITS'(1);
            end else if (r_hold != '0) begin
               r_hold <= r_hold - HOLD_BITS'(1);
            end
         end else begin
            r_hold <= '0;
         end
      end
   end

   assign instr_ready_o = w_instr_ready;
   assign rs1_addr_o    = r_rs1_addr;
   assign rs2_addr_o    = r_rs2_addr;
   assign op_valid_o    = r_op_valid;
   assign op_rs1_o      = r_op_rs1;
   assign op_rs2_o      = r_op_rs2;
   assign op_instr_o    = r_instr;
   assign op_pc_o       = r_pc;

endmodule

// File: tb/tb_rv32i_operand_fetch.sv
// tb_rv32i_operand_fetch: directed + randomized bench with a transaction-level model of
// operand delivery and a BRAM register file model that also serves as the architectural state.
module tb_rv32i_operand_fetch;

`ifdef RV32I_OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        wb_write = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        flush = 1'b0;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [31:0] op_rs1;
   logic [31:0] op_rs2;
   logic [31:0] op_instr;
   logic [31:0] op_pc;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   rv32i_operand_fetch #(.XLEN(32), .REG_BITS(5)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .instr_i(instr), .pc_i(pc),
      .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
      .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
      .wb_write_i(wb_write), .wb_rd_addr_i(wb_rd), .wb_data_i(wb_data),
      .flush_i(flush),
      .op_valid_o(op_valid), .op_ready_i(op_ready),
      .op_rs1_o(op_rs1), .op_rs2_o(op_rs2),
      .op_instr_o(op_instr), .op_pc_o(op_pc)
   );

   always #5 clk = ~clk;

   // Register file BRAM: registered read, read-first on a same-edge write.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      rs1_data <= mem[rs1_addr];
      rs2_data <= mem[rs2_addr];
      if (wb_write) mem[wb_rd] <= wb_data;
   end

   function automatic logic [31:0] arch(input logic [4:0] r);
      return (r == 5'd0) ? 32'h0 : mem[r];
   endfunction

   // Transaction model: one instruction in flight, valid at a predicted edge.
   bit          m_busy = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc = '0;
   int          m_valid_at = 0;
   int          n_edge = 0;

   function automatic logic exp_ready();
      return !flush && (!m_busy || (m_valid && op_ready));
   endfunction

   function automatic bit hazard(input logic [31:0] ins);
      logic [4:0] a1, a2;
      a1 = ins[19:15];
      a2 = ins[24:20];
      return wb_write && (wb_rd != 5'd0) && ((wb_rd == a1) || (wb_rd == a2));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
      end else begin
         logic rdy;
         n_edge++;
         rdy = exp_ready();
         if (flush) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
         end else begin
            if (!BYP && m_busy && !m_valid && hazard(m_instr)) m_valid_at += 2;
            if (!BYP && m_busy && m_valid && !op_ready && hazard(m_instr)) begin
               m_valid    = 1'b0;
               m_valid_at = n_edge + 2;
            end
            if (m_busy && m_valid && op_ready) begin
               m_busy  = 1'b0;
               m_valid = 1'b0;
            end
            if (instr_valid && rdy) begin
               m_busy     = 1'b1;
               m_valid    = 1'b0;
               m_instr    = instr;
               m_pc       = pc;
               m_valid_at = n_edge + 2;
            end
            if (m_busy && !m_valid && (n_edge == m_valid_at)) m_valid = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("instr_ready", 32'(instr_ready), 32'(exp_ready()));
         check("op_valid", 32'(op_valid), 32'(m_valid));
         if (m_valid) begin
            check("op_rs1", op_rs1, arch(m_instr[19:15]));
            check("op_rs2", op_rs2, arch(m_instr[24:20]));
            check("op_instr", op_instr, m_instr);
            check("op_pc", op_pc, m_pc);
         end
         if (m_busy) begin
            check("rs1_addr", 32'(rs1_addr), 32'(m_instr[19:15]));
            check("rs2_addr", 32'(rs2_addr), 32'(m_instr[24:20]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      wb_write = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
      tick();
      wb_write = 1'b0;
   endtask

   task automatic accept(input logic [31:0] ins, input logic [31:0] p);
      instr       = ins;
      pc          = p;
      instr_valid = 1'b1;
      #1;
      check("accept_ready", 32'(instr_ready), 32'd1);
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic consume();
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
   endtask

   task automatic run_to_valid(input int start, output int lat);
      lat = start;
      while ((op_valid !== 1'b1) && (lat < 30)) begin
         tick();
         lat++;
      end
   endtask

   localparam logic [31:0] ADD_765 = 32'h006283B3;
   localparam logic [31:0] ADD_706 = 32'h006003B3;

   initial begin
      int lat;
      logic [31:0] ri;

      chk_en = 1'b1;
      #2;
      check("rst_op_valid", 32'(op_valid), 32'd0);
      check("rst_op_rs1", op_rs1, 32'd0);
      check("rst_op_pc", op_pc, 32'd0);
      check("rst_rs1_addr", 32'(rs1_addr), 32'd0);
      check("rst_ready", 32'(instr_ready), 32'd1);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      wb(5'd5, 32'h0000_1234);
      wb(5'd6, 32'h0000_ABCD);
      wb(5'd0, 32'hFFFF_FFFF);

      // add x7,x5,x6: addresses held through SETUP and FETCH, valid after two edges
      accept(ADD_765, 32'h100);
      check("t1_setup_rs1a", 32'(rs1_addr), 32'd5);
      check("t1_setup_rs2a", 32'(rs2_addr), 32'd6);
      check("t1_setup_valid", 32'(op_valid), 32'd0);
      tick();
      check("t1_fetch_rs1a", 32'(rs1_addr), 32'd5);
      check("t1_fetch_valid", 32'(op_valid), 32'd0);
      tick();
      check("t1_valid", 32'(op_valid), 32'd1);
      check("t1_rs1", op_rs1, 32'h0000_1234);
      check("t1_rs2", op_rs2, 32'h0000_ABCD);
      check("t1_instr", op_instr, ADD_765);
      consume();

      // x0 reads zero despite the BRAM holding all ones
      accept(ADD_706, 32'h104);
      run_to_valid(0, lat);
      check("t2_latency", 32'(lat), 32'd2);
      check("t2_rs1", op_rs1, 32'd0);
      check("t2_rs2", op_rs2, 32'h0000_ABCD);

      // Execute stalls: operands held, no new accept
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_valid", 32'(op_valid), 32'd1);
         check("t4_hold_rs2", op_rs2, 32'h0000_ABCD);
         check("t4_hold_ready", 32'(instr_ready), 32'd0);
      end
      op_ready = 1'b1;
      accept(ADD_765, 32'h108);
      op_ready = 1'b0;
      run_to_valid(0, lat);
      check("t4_b2b_latency", 32'(lat), 32'd2);
      check("t4_b2b_pc", op_pc, 32'h108);
      check("t4_b2b_rs1", op_rs1, 32'h0000_1234);
      consume();

      // Writeback to x5 during SETUP
      accept(ADD_765, 32'h10C);
      wb(5'd5, 32'hDEAD_BEEF);
      run_to_valid(1, lat);
      check("t3_latency", 32'(lat), BYP ? 32'd2 : 32'd4);
      check("t3_rs1", op_rs1, 32'hDEAD_BEEF);
      check("t3_rs2", op_rs2, 32'h0000_ABCD);
      consume();

      // Flush during FETCH
      accept(ADD_765, 32'h110);
      tick();
      flush = 1'b1;
      #1;
      check("t5_ready_in_flush", 32'(instr_ready), 32'd0);
      tick();
      flush = 1'b0;
      check("t5_valid_after_flush", 32'(op_valid), 32'd0);
      #1;
      check("t5_ready_after_flush", 32'(instr_ready), 32'd1);
      tick();
      check("t5_still_idle", 32'(op_valid), 32'd0);

      // Asynchronous reset while operands are presented
      accept(ADD_765, 32'h114);
      run_to_valid(0, lat);
      check("t6_pre_valid", 32'(op_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(op_valid), 32'd0);
      check("t6_async_rs1", op_rs1, 32'd0);
      check("t6_async_rs2", op_rs2, 32'd0);
      check("t6_async_instr", op_instr, 32'd0);
      check("t6_async_pc", op_pc, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check("t6_ready_after", 32'(instr_ready), 32'd1);
      tick();
      check("t6_valid_after", 32'(op_valid), 32'd0);

      // Randomized traffic on a small register window to provoke hazards
      for (int c = 0; c < 3000; c++) begin
         ri          = $urandom;
         ri[19:15]   = 5'($urandom_range(0, 7));
         ri[24:20]   = 5'($urandom_range(0, 7));
         instr       = ri;
         pc          = $urandom;
         instr_valid = ($urandom_range(0, 9) < 6);
         op_ready    = ($urandom_range(0, 9) < 6);
         wb_write    = ($urandom_range(0, 9) < 4);
         wb_rd       = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
         flush       = ($urandom_range(0, 99) < 3);
         tick();
      end
      instr_valid = 1'b0;
      wb_write    = 1'b0;
      flush       = 1'b0;
      op_ready    = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
